// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: two-stage pipelined shifter supporting SLL, SRL, SRA and ROL.
// It has a valid/ready handshake on both sides and produces carry-out and zero flags.
// Stage 1 applies the low shift-amount levels and stage 2 applies the remaining levels.
// Datapath registers load only on their stage-advance term, so an ALU can use those
// terms as clock-gate enables. The 'active' output requests the block clock.
module shift_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             active
);

  // The low LOW amount bits are applied in stage 1.
  // The upper HIW bits travel with the partial result to stage 2.
  localparam int LOW = SHW / 2;
  localparam int HIW = SHW - LOW;

  typedef enum logic [1:0] {
    MODE_SLL = 2'd0,
    MODE_SRL = 2'd1,
    MODE_SRA = 2'd2,
    MODE_ROL = 2'd3
  } mode_t;

  // Both stages share one shifter function. A rotate is the upper half of the
  // doubled operand shifted left, which avoids a (WIDTH - amt) subtraction.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                input logic [SHW-1:0]   amt,
                                                input mode_t            mode);
    logic [2*WIDTH-1:0] dbl;
    dbl = {v, v} << amt;
    case (mode)
      MODE_SLL: shift_by = v << amt;
      MODE_SRL: shift_by = v >> amt;
      MODE_SRA: shift_by = $signed(v) >>> amt;
      default:  shift_by = dbl[2*WIDTH-1:WIDTH];
    endcase
  endfunction

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             s1_load;
  logic             s2_load;
  mode_t            in_mode_e;
  mode_t            s1_mode;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] s1_shifted;
  logic [WIDTH-1:0] s2_result;
  logic [HIW-1:0]   s1_amt_hi;
  logic             s1_carry;
  logic             carry_next;
  logic [SHW-1:0]   lo_amt;
  logic [SHW-1:0]   hi_amt;
  logic [SHW-1:0]   neg_amt;
  logic [SHW-1:0]   dec_amt;

  // A stage may take new data when it is empty or when its content moves on this edge.
  assign s2_adv  = !s2_valid || out_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign s1_load = in_valid && s1_adv;
  assign s2_load = s1_valid && s2_adv;

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign active    = s1_valid || s2_valid;

  assign in_mode_e  = mode_t'(in_mode);
  assign lo_amt     = {{HIW{1'b0}}, in_amt[LOW-1:0]};
  assign hi_amt     = {s1_amt_hi, {LOW{1'b0}}};
  assign s1_shifted = shift_by(in_data, lo_amt, in_mode_e);
  assign s2_result  = shift_by(s1_data, hi_amt, s1_mode);

  // WIDTH is a power of two, so WIDTH-amt wraps naturally to -amt in SHW bits.
  assign neg_amt = SHW'(0) - in_amt;
  assign dec_amt = in_amt - SHW'(1);

  // Compute the carry from the original operand.
  // For left shifts and rotates it is the last bit that left the top.
  // For right shifts it is the last bit that left the bottom.
  always_comb begin
    carry_next = 1'b0;
    if (in_amt != '0) begin
      if (in_mode_e == MODE_SLL || in_mode_e == MODE_ROL) begin
        carry_next = in_data[neg_amt];
      end else begin
        carry_next = in_data[dec_amt];
      end
    end
  end

  // Valid bits follow the advance rules. A reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
    end
  end

  // Stage 1 data registers load only on an accepted input and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data   <= '0;
      s1_mode   <= MODE_SLL;
      s1_amt_hi <= '0;
      s1_carry  <= 1'b0;
    end else if (s1_load) begin
      s1_data   <= s1_shifted;
      s1_mode   <= in_mode_e;
      s1_amt_hi <= in_amt[SHW-1:LOW];
      s1_carry  <= carry_next;
    end
  end

  // Stage 2 result registers load only when stage 1 moves forward.
  // This keeps the result stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else if (s2_load) begin
      out_data  <= s2_result;
      out_carry <= s1_carry;
      out_zero  <= (s2_result == '0);
    end
  end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe: directed bench for shift_unit_pipe at WIDTH=16 and WIDTH=32.
// A queue-based reference model predicts every result from the shift rules.
module tb_shift_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [3:0]  in_amt;
  logic [1:0]  in_mode;
  logic        out_carry, out_zero, active;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] in_data32, out_data32;
  logic [4:0]  in_amt32;
  logic [1:0]  in_mode32;
  logic        out_carry32, out_zero32, active32;

  typedef struct {
    logic [63:0] data;
    logic        carry;
    logic        zero;
  } exp_t;

  exp_t        q16[$];
  exp_t        q32[$];
  int          checks = 0;
  int          errors = 0;
  int          acc16 = 0, xfer16 = 0, acc32 = 0, xfer32 = 0;
  logic [63:0] m16_r, m32_r, last16, pr;
  logic        m16_c, m32_c, pc;
  logic        stop_toggle;

  shift_unit_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry),
    .out_zero(out_zero), .active(active)
  );

  shift_unit_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_amt(in_amt32), .in_mode(in_mode32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_data(out_data32), .out_carry(out_carry32),
    .out_zero(out_zero32), .active(active32)
  );

  always #5 clk = ~clk;

  // The reference shift is computed with plain arithmetic on a 64-bit word masked to w bits.
  function automatic void ref_shift(input int w, input logic [63:0] din, input int amt,
                                    input int mode, output logic [63:0] r, output logic c);
    logic [63:0] mask;
    logic [63:0] d;
    mask = (64'd1 << w) - 64'd1;
    d = din & mask;
    case (mode)
      0: r = (d << amt) & mask;
      1: r = d >> amt;
      2: begin
        r = d >> amt;
        if (d[w-1]) r = r | (mask & ~(mask >> amt));
      end
      default: r = ((d << amt) | (d >> (w - amt))) & mask;
    endcase
    if (amt == 0) c = 1'b0;
    else if (mode == 0 || mode == 3) c = d[w-amt];
    else c = d[amt-1];
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Check the 16-bit outputs against the oldest pending prediction on every valid cycle.
  // Retire that prediction when the transfer happens, and record each accepted input.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL out16_unexpected: got out_valid=1 data 0x%0h, expected no result", out_data);
        end else begin
          check_val("out16_data", out_data, q16[0].data);
          check_val("out16_carry", out_carry, q16[0].carry);
          check_val("out16_zero", out_zero, q16[0].zero);
          if (out_ready) begin
            void'(q16.pop_front());
            xfer16++;
          end
        end
      end
      if (in_valid && in_ready) begin
        ref_shift(16, 64'(in_data), int'(in_amt), int'(in_mode), m16_r, m16_c);
        q16.push_back('{m16_r, m16_c, (m16_r == 64'd0)});
        last16 = m16_r;
        acc16++;
      end
    end
  end

  // The 32-bit instance is checked the same way.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid32) begin
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL out32_unexpected: got out_valid=1 data 0x%0h, expected no result", out_data32);
        end else begin
          check_val("out32_data", out_data32, q32[0].data);
          check_val("out32_carry", out_carry32, q32[0].carry);
          check_val("out32_zero", out_zero32, q32[0].zero);
          if (out_ready32) begin
            void'(q32.pop_front());
            xfer32++;
          end
        end
      end
      if (in_valid32 && in_ready32) begin
        ref_shift(32, 64'(in_data32), int'(in_amt32), int'(in_mode32), m32_r, m32_c);
        q32.push_back('{m32_r, m32_c, (m32_r == 64'd0)});
        acc32++;
      end
    end
  end

  // Present one operation and hold it until it is accepted. The task returns 1ns after the accepting edge.
  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept16_timeout: got in_ready=0 for %0d cycles, expected accept", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_stimulus32(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m);
    int n;
    n = 0;
    in_valid32 = 1'b1;
    in_data32  = d;
    in_amt32   = a;
    in_mode32  = m;
    @(negedge clk);
    while (!in_ready32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept32_timeout: got in_ready=0 for %0d cycles, expected accept", n);
    end
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
  endtask

  // Compare the 16-bit outputs with literal values at the next negedge, then return 1ns after the following posedge.
  task automatic check_output(input string name, input logic v, input logic [15:0] d,
                              input logic c, input logic z);
    @(negedge clk);
    check_val({name, "_valid"}, out_valid, v);
    if (v) begin
      check_val({name, "_data"}, out_data, d);
      check_val({name, "_carry"}, out_carry, c);
      check_val({name, "_zero"}, out_zero, z);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle16(input string name);
    int n;
    n = 0;
    while ((active || q16.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({name, "_active"}, active, 0);
    check_val({name, "_pending"}, 64'(q16.size()), 0);
    check_val({name, "_count"}, 64'(xfer16), 64'(acc16));
  endtask

  task automatic wait_idle32(input string name);
    int n;
    n = 0;
    while ((active32 || q32.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({name, "_active"}, active32, 0);
    check_val({name, "_pending"}, 64'(q32.size()), 0);
    check_val({name, "_count"}, 64'(xfer32), 64'(acc32));
  endtask

  // A watchdog bounds the whole run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b0;
    in_valid32 = 1'b0; in_data32 = '0; in_amt32 = '0; in_mode32 = '0; out_ready32 = 1'b0;
    stop_toggle = 1'b1;
    last16 = '0;
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_active", active, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_carry", out_carry, 0);
    check_val("rst_out_zero", out_zero, 0);
    check_val("rst32_out_valid", out_valid32, 0);
    check_val("rst32_in_ready", in_ready32, 1);

    // Pin the reference model with hand-computed literal cases.
    ref_shift(16, 64'h8001, 1, 0, pr, pc);  check_val("model_sll", pr, 64'h0002);  check_val("model_sll_c", pc, 1);
    ref_shift(16, 64'h8001, 1, 1, pr, pc);  check_val("model_srl", pr, 64'h4000);  check_val("model_srl_c", pc, 1);
    ref_shift(16, 64'h8001, 4, 2, pr, pc);  check_val("model_sra", pr, 64'hF800);  check_val("model_sra_c", pc, 0);
    ref_shift(16, 64'h8001, 4, 3, pr, pc);  check_val("model_rol", pr, 64'h0018);  check_val("model_rol_c", pc, 0);
    ref_shift(16, 64'hFFFF, 15, 0, pr, pc); check_val("model_sll15", pr, 64'h8000); check_val("model_sll15_c", pc, 1);
    ref_shift(16, 64'h1234, 0, 2, pr, pc);  check_val("model_amt0", pr, 64'h1234); check_val("model_amt0_c", pc, 0);
    ref_shift(32, 64'h80000001, 31, 3, pr, pc); check_val("model_rol31", pr, 64'hC0000000); check_val("model_rol31_c", pc, 0);
    ref_shift(32, 64'h80000001, 4, 2, pr, pc);  check_val("model_sra32", pr, 64'hF8000000);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    out_ready32 = 1'b1;

    $display("[TB] latency and literal results");
    apply_stimulus(16'h8001, 4'd1, 2'd0);
    check_val("lat_active", active, 1);
    check_output("lat_sll_early", 1'b0, 16'h0, 1'b0, 1'b0);
    check_output("lat_sll", 1'b1, 16'h0002, 1'b1, 1'b0);
    apply_stimulus(16'h8001, 4'd1, 2'd1);
    check_output("lat_srl_early", 1'b0, 16'h0, 1'b0, 1'b0);
    check_output("lat_srl", 1'b1, 16'h4000, 1'b1, 1'b0);
    apply_stimulus(16'h0001, 4'd1, 2'd1);
    check_output("lat_zero_early", 1'b0, 16'h0, 1'b0, 1'b0);
    check_output("lat_zero", 1'b1, 16'h0000, 1'b1, 1'b1);

    $display("[TB] back-to-back directed vectors and amount sweep");
    apply_stimulus(16'h8001, 4'd4, 2'd2);
    apply_stimulus(16'h8001, 4'd4, 2'd3);
    for (int m = 0; m < 4; m++) apply_stimulus(16'h1234, 4'd0, 2'(m));
    apply_stimulus(16'hFFFF, 4'd15, 2'd0);
    apply_stimulus(16'h0000, 4'd5, 2'd3);
    for (int p = 0; p < 2; p++)
      for (int m = 0; m < 4; m++)
        for (int a = 0; a < 16; a++)
          apply_stimulus(p == 0 ? 16'hB5C3 : 16'h4A3C, 4'(a), 2'(m));
    wait_idle16("sweep");

    $display("[TB] backpressure");
    out_ready = 1'b0;
    apply_stimulus(16'h8421, 4'd3, 2'd1);
    apply_stimulus(16'hC3A5, 4'd9, 2'd2);
    in_valid = 1'b1; in_data = 16'h0F0F; in_amt = 4'd6; in_mode = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_in_ready", in_ready, 0);
      check_val("bp_out_valid", out_valid, 1);
      check_val("bp_held_data", out_data, 16'h1084);
      @(posedge clk);
      #1;
    end
    stop_toggle = 1'b0;
    fork
      begin
        while (!stop_toggle) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    apply_stimulus(16'h0F0F, 4'd6, 2'd3);
    apply_stimulus(16'h7FFE, 4'd13, 2'd2);
    apply_stimulus(16'h1001, 4'd12, 2'd0);
    for (int i = 0; i < 6; i++) apply_stimulus(16'(16'h3C5A + i * 16'h0111), 4'(i * 3), 2'(i));
    stop_toggle = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_idle16("bp");

    $display("[TB] idle hold");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      in_data = 16'($urandom);
      in_amt  = 4'($urandom);
      in_mode = 2'($urandom);
      @(negedge clk);
      check_val("idle_out_data", out_data, last16);
      check_val("idle_active", active, 0);
    end
    @(posedge clk);
    #1;

    $display("[TB] full-pipe pass-through");
    out_ready = 1'b0;
    apply_stimulus(16'h1357, 4'd3, 2'd0);
    apply_stimulus(16'h9ACE, 4'd5, 2'd2);
    in_valid = 1'b1; in_data = 16'h2468; in_amt = 4'd7; in_mode = 2'd3;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("pass_in_ready", in_ready, 1);
    check_val("pass_out_valid", out_valid, 1);
    check_val("pass_out_data", out_data, 16'h9AB8);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("pass_moved_valid", out_valid, 1);
    check_val("pass_moved_data", out_data, 16'hFCD6);
    @(posedge clk);
    #1;
    wait_idle16("pass");

    $display("[TB] reset with operations in flight");
    out_ready = 1'b0;
    apply_stimulus(16'h00FF, 4'd2, 2'd0);
    apply_stimulus(16'hFF00, 4'd2, 2'd1);
    #2;
    rst_n = 1'b0;
    q16.delete();
    acc16 = 0;
    xfer16 = 0;
    #1;
    check_val("rmid_out_valid", out_valid, 0);
    check_val("rmid_active", active, 0);
    check_val("rmid_in_ready", in_ready, 1);
    check_val("rmid_out_data", out_data, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("rmid_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    $display("[TB] WIDTH=32 cases");
    apply_stimulus32(32'h80000001, 5'd4, 2'd3);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("w32_rol_valid", out_valid32, 1);
    check_val("w32_rol_data", out_data32, 32'h00000018);
    check_val("w32_rol_carry", out_carry32, 0);
    @(posedge clk);
    #1;
    apply_stimulus32(32'h80000001, 5'd1, 2'd0);
    apply_stimulus32(32'h80000001, 5'd1, 2'd1);
    apply_stimulus32(32'h80000001, 5'd4, 2'd2);
    apply_stimulus32(32'hFFFFFFFF, 5'd31, 2'd0);
    apply_stimulus32(32'h80000001, 5'd31, 2'd3);
    apply_stimulus32(32'h00000001, 5'd1, 2'd1);
    for (int m = 0; m < 4; m++) apply_stimulus32(32'h12345678, 5'd0, 2'(m));
    for (int p = 0; p < 2; p++)
      for (int m = 0; m < 4; m++)
        for (int a = 0; a < 32; a++)
          apply_stimulus32(p == 0 ? 32'h9ABCDEF1 : 32'h6543210E, 5'(a), 2'(m));
    wait_idle32("w32");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
